// File: rtl/pio_input_debounce_irq.sv
// Avalon-MM input port: synchronised, debounced inputs with edge capture,
// per-bit interrupt mask and a level interrupt.
module pio_input_debounce_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt    [WIDTH];
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic [SW-1:0]    settle;
    logic             armed;
    logic             wr;
    logic             unused_wdata;

    assign raw          = sync_q[SYNC_STAGES-1];
    assign wr           = chipselect & ~write_n;
    assign clr          = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign irq          = |(capture & mask);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // A bit is accepted only after disagreeing for DEBOUNCE_CYCLES clocks in a row
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (raw[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    deb[i] <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        case (EDGE_MODE)
            0:       edges = deb & ~deb_prev;
            1:       edges = ~deb & deb_prev;
            default: edges = deb ^ deb_prev;
        endcase
    end

    // Capture stays disarmed until inputs held at reset have settled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle   <= '0;
            armed    <= 1'b0;
            deb_prev <= '0;
            mask     <= '0;
            capture  <= '0;
        end else begin
            deb_prev <= deb;
            if (!armed) begin
                if (settle == SETTLE_MAX) armed <= 1'b1;
                else settle <= settle + SW'(1);
            end
            if (wr && address == 2'd2) mask <= writedata[WIDTH-1:0];
            capture <= (capture & ~clr) | (edges & {WIDTH{armed}});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(deb);
                2'd1:    readdata <= 32'(raw);
                2'd2:    readdata <= 32'(mask);
                default: readdata <= 32'(capture);
            endcase
        end
    end

endmodule

// File: tb/tb_pio_input_debounce_irq.sv
// Directed bench for pio_input_debounce_irq: rising-edge instance plus
// an any-edge instance sharing the bus.
module tb_pio_input_debounce_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [9:0]  in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] rd1;
    logic [31:0] rd2;

    pio_input_debounce_irq #(
        .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    pio_input_debounce_irq #(
        .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port2), .readdata(readdata2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  bit_i;
        logic [4:0]  len;
        logic [31:0] exp_cap;
        logic        exp_irq;
    } pulse_t;

    typedef struct packed {
        logic        exp_irq;
        logic [31:0] exp_rd;
    } lat_t;

    pulse_t ptbl [5];
    lat_t   ltbl [8];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        rd1        = readdata;
        rd2        = readdata2;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic irq_seen;

        ptbl[0] = '{bit_i: 4'd4, len: 5'd3, exp_cap: 32'h000, exp_irq: 1'b0};
        ptbl[1] = '{bit_i: 4'd4, len: 5'd4, exp_cap: 32'h010, exp_irq: 1'b1};
        ptbl[2] = '{bit_i: 4'd4, len: 5'd1, exp_cap: 32'h000, exp_irq: 1'b0};
        ptbl[3] = '{bit_i: 4'd7, len: 5'd8, exp_cap: 32'h080, exp_irq: 1'b1};
        ptbl[4] = '{bit_i: 4'd2, len: 5'd4, exp_cap: 32'h004, exp_irq: 1'b1};

        for (int e = 0; e < 8; e++) ltbl[e] = '{exp_irq: 1'b0, exp_rd: 32'h0};
        ltbl[6] = '{exp_irq: 1'b1, exp_rd: 32'h0};
        ltbl[7] = '{exp_irq: 1'b1, exp_rd: 32'h1};

        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h3FF;
        in_port2   = 10'h3FF;

        // Inputs held high through reset: no spurious capture
        reset_n = 1'b0;
        tick();
        tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        wr(2'd2, 32'h3FF);
        irq_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (irq || irq2) irq_seen = 1'b1;
        end
        check("settle_no_irq", {31'b0, irq_seen}, 32'h0);
        rd(2'd0);
        check("settle_data", rd1, 32'h3FF);
        rd(2'd1);
        check("settle_raw", rd1, 32'h3FF);
        rd(2'd3);
        check("settle_capture", rd1, 32'h0);
        check("settle_capture2", rd2, 32'h0);

        // Latency of a single rising edge on bit 0
        in_port = 10'h000;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        wr(2'd2, 32'h001);
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b1;
        in_port    = 10'h001;
        for (int e = 0; e < 8; e++) begin
            tick();
            check($sformatf("lat_irq_e%0d", e + 1), {31'b0, irq},
                  {31'b0, ltbl[e].exp_irq});
            check($sformatf("lat_rd_e%0d", e + 1), readdata, ltbl[e].exp_rd);
        end
        chipselect = 1'b0;
        wr(2'd3, 32'h3FF);
        wr(2'd2, 32'h3FF);

        // Pulse-width table
        for (int p = 0; p < 5; p++) begin
            in_port = 10'h001 | (10'h001 << ptbl[p].bit_i);
            repeat (int'(ptbl[p].len)) tick();
            in_port = 10'h001;
            repeat (15) tick();
            rd(2'd3);
            check($sformatf("pulse%0d_cap", p), rd1, ptbl[p].exp_cap);
            check($sformatf("pulse%0d_irq", p), {31'b0, irq},
                  {31'b0, ptbl[p].exp_irq});
            wr(2'd3, 32'h3FF);
        end

        // Falling edge ignored, partial clear, clear vs set on same edge
        in_port = 10'h000;
        repeat (10) tick();
        rd(2'd3);
        check("fall_ignored", rd1, 32'h0);
        in_port = 10'h011;
        repeat (10) tick();
        rd(2'd3);
        check("cap_011", rd1, 32'h011);
        wr(2'd2, 32'h010);
        check("irq_mask10", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h001);
        rd(2'd3);
        check("cap_after_clr", rd1, 32'h010);
        check("irq_after_clr", {31'b0, irq}, 32'h1);
        in_port = 10'h001;
        repeat (10) tick();
        wr(2'd3, 32'h3FF);
        rd(2'd3);
        check("cap_cleared", rd1, 32'h0);
        in_port = 10'h011;
        repeat (6) tick();
        wr(2'd3, 32'h010);
        rd(2'd3);
        check("set_wins", rd1, 32'h010);

        // Any-edge instance on bit 9
        in_port2 = 10'h1FF;
        repeat (10) tick();
        rd(2'd3);
        check("any_fall", rd2, 32'h200);
        check("any_irq_masked", {31'b0, irq2}, 32'h0);
        wr(2'd2, 32'h200);
        check("any_irq_unmask", {31'b0, irq2}, 32'h1);
        wr(2'd3, 32'h200);
        rd(2'd3);
        check("any_cleared", rd2, 32'h0);
        in_port2 = 10'h3FF;
        repeat (10) tick();
        rd(2'd3);
        check("any_rise", rd2, 32'h200);

        // Reset in the middle of operation
        in_port = 10'h000;
        repeat (10) tick();
        wr(2'd3, 32'h3FF);
        in_port = 10'h3FF;
        repeat (10) tick();
        rd(2'd3);
        check("full_cap", rd1, 32'h3FF);
        wr(2'd2, 32'h3FF);
        check("full_irq", {31'b0, irq}, 32'h1);
        address    = 2'd2;
        chipselect = 1'b1;
        write_n    = 1'b1;
        reset_n    = 1'b0;
        tick();
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        check("mid_rst_rd", readdata, 32'h0);
        reset_n    = 1'b1;
        chipselect = 1'b0;
        rd(2'd3);
        check("mid_rst_cap", rd1, 32'h0);
        rd(2'd2);
        check("mid_rst_mask", rd1, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pio_input_debounce_irq.md
Name: pio_input_debounce_irq

Overview:
Parametrised Avalon-MM slave input port: a successor to the plain slider-switch PIO. It synchronises and debounces WIDTH asynchronous inputs and exposes the debounced data plus raw synchronised data. Adds edge capture with a selectable edge mode, a per-bit interrupt mask and a level interrupt to the processor. Sits on the lightweight bus alongside the other PIO peripherals; used for switches and pushbuttons.

Parameters:
WIDTH, 10, number of input bits (1..32); readdata zero-extended above WIDTH.
SYNC_STAGES, 2, synchroniser flop count (>=2).
DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised bit must differ from debounced state before acceptance (>=1; 1 = accept next clock).
EDGE_MODE, 0, 0 rising, 1 falling, 2 any edge; other values treated as 2.

Ports:
clk  input  1  system clock; single clock domain.
reset_n  input  1  synchronous, active-low reset.
address  input  2  word address: 0 data, 1 raw, 2 irq mask, 3 edge capture.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe, qualified by chipselect.
writedata  input  32  write data.
in_port  input  WIDTH  asynchronous external inputs.
readdata  output  32  registered read data.
irq  output  1  level interrupt, active high.

Behaviour:
- Reset (reset_n low at posedge clk): sync chain, raw, deb, deb_prev, per-bit counters, mask, capture, readdata all 0; settle counter 0; armed 0. irq therefore 0.
- Sync: in_port passes SYNC_STAGES flops; last stage = raw.
- Debounce, per bit i, each clock: raw[i]==deb[i] -> cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 -> deb[i]<=raw[i], cnt<=0; else cnt++. Any return to agreement before acceptance restarts counting. Counter width = clog2(DEBOUNCE_CYCLES), minimum 1.
- Latency: stable change presented before sampling edge k -> raw updates at edge k+SYNC_STAGES-1 -> deb at edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES -> capture bit set one edge later.
- Edge detect: deb_prev<=deb every clock. edge = deb&~deb_prev (mode 0), ~deb&deb_prev (mode 1), deb^deb_prev (mode 2).
- Arming: settle counter increments after reset until SYNC_STAGES+DEBOUNCE_CYCLES+1, then armed=1 and holds. While armed=0, edges are not captured, so inputs held high at reset produce no spurious capture.
- Capture: capture <= (capture & ~clr) | (edge & {WIDTH{armed}}). clr = writedata[WIDTH-1:0] when write to address 3, else 0. Simultaneous clear and new edge on the same bit: set wins.
- Mask: write to address 2 loads writedata[WIDTH-1:0]. Writes to addresses 0/1 are ignored. A write is chipselect=1 and write_n=0, taking effect at that edge.
- irq = |(capture & mask), combinational from registers, no added latency. Unmasking an already-captured bit asserts irq in the cycle after the mask write.
- Read: readdata registered every clock from address mux (0 deb, 1 raw, 2 mask, 3 capture), zero-extended. One-cycle read latency. Reads have no side effects. readdata reflects register values before same-edge updates.
- Reset mid-operation: all state returns to reset values at that edge. Re-arming is required; pending captures and mask are lost.

Test Plan:
(WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0 unless stated.)
- Reset, in_port=10'h3FF held -> data reads 0x3FF after settle; capture reads 0; irq stays 0 throughout.
- in_port 0->10'h001 before edge 1 -> deb bit0 at edge 6; capture=0x001 at edge 7; address-3 readdata shows 0x001 at edge 8. With mask=0x001, irq=1 after edge 7.
- 3-cycle pulse on bit 4 (raw high 3 clocks) -> deb, capture, irq unchanged; 4-cycle pulse -> capture=0x010.
- capture=0x011, write 0x001 to address 3 -> capture=0x010; with mask=0x010, irq stays 1. Write 0x010 in the same cycle bit 4 re-edges -> bit 4 remains 1.
- EDGE_MODE=2, bit 9 toggled 1->0->1 with 10-cycle spacing -> capture bit 9 set after each edge. Clear between edges -> set again.
- reset_n low for 1 clock while capture=0x3FF and mask=0x3FF -> capture=0, mask=0, irq=0, readdata=0 after that edge.
